rotate_right_seq: RTL and testbench
===================================

# rotate_right_seq

Multi-cycle rotate-right unit for the Phase 1 datapath ALU. It complements the combinational rotate-left path. It accepts a 32-bit operand and a rotate amount, of which only the lower 5 bits are used. It rotates one bit position per clock under a small FSM, then signals completion with a one-cycle `done` pulse. The ALU control sequencer starts it and waits on `done` before latching the result into Z.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width. Only 32 is supported.
- `SHAMT_W`, 5, number of low bits of `rotateBy` that are used.

Ports:
- `clock`  in  1  Single clock. All state changes on the rising edge.
- `clear`  in  1  Reset. Synchronous and active-high.
- `start`  in  1  Request. Sampled only in IDLE or DONE.
- `unrotated`  in  32  Operand. Latched on accepted `start`.
- `rotateBy`  in  32  Rotate amount. Only `rotateBy[4:0]` is latched.
- `rotated`  out  32  Result register. Final only while `done` is high, then held.
- `busy`  out  1  High in SHIFT.
- `done`  out  1  One-cycle completion pulse, high in DONE.

## Operation
- States: IDLE, SHIFT, DONE. Encoded in 2 bits; the unused encoding goes to IDLE.
- Accepting a request (IDLE or DONE with `start`=1):
  - `rotated` ← `unrotated`; `remaining` ← `rotateBy[4:0]`.
  - Next state is SHIFT if `remaining`≠0, otherwise DONE.
- SHIFT, each cycle:
  - `rotated` ← {`rotated[0]`, `rotated[31:1]`}; `remaining` ← `remaining`−1.
  - On the cycle that drives `remaining` from 1 to 0, next state is DONE.
- DONE:
  - `done`=1 for exactly one cycle. Next state is IDLE unless `start`=1 (back-to-back accept per the rule above).
  - `rotated` is held through DONE and IDLE until the next accepted `start`.
- `start` during SHIFT is ignored. The operation in flight is not disturbed, and no request is queued.
- Upper bits `rotateBy[31:5]` are ignored, so an amount of 32 behaves as 0 and 33 as 1.
- Inputs may change freely after the accept edge.
- `remaining` is a 5-bit down-counter and never wraps below 0.

## Timing
- Reset values: state=IDLE, `rotated`=32'h0, `remaining`=0, `busy`=0, `done`=0.
- `clear` wins over every other condition on the same edge, including mid-SHIFT. A cleared operation produces no `done`.
- Latency: with the accept edge E and amount n, `done` is high in the cycle following edge E+n. For n=0 this is the cycle right after E.
- `busy` is high for exactly n cycles.
- Throughput: back-to-back accept from DONE gives one result per n+1 cycles. An n=0 stream gives one result per cycle.
- `rotated` shows intermediate values during SHIFT. The consumer uses it only while `done`=1 or afterwards.

## Configuration
- Macro `ROR_NIBBLE_STEP_EN`.
- Defined:
  - Each SHIFT cycle rotates by 4 (`rotated` ← {`rotated[3:0]`, `rotated[31:4]`}, `remaining`−4) when `remaining`≥4, otherwise by 1.
  - Latency becomes ⌊n/4⌋+(n mod 4); for example n=31 gives 10 cycles and n=8 gives 2.
  - `busy` is high for that many cycles.
- Undefined: one bit per cycle as specified above.
- Final results are identical in both builds; only cycle counts differ.

## Test plan
- Reset and idle: assert `clear` for 2 cycles. Outputs are 0, `busy`=0, `done`=0, and `start`=0 keeps them there.
- Basic rotate: `unrotated`=32'h0000_0001, `rotateBy`=1 gives `rotated`=32'h8000_0000. `done` is high one cycle after the accept+1 edge, and `busy` is high for 1 cycle.
- Max and masking:
  - 32'h1234_5678 by 4 gives 32'h8123_4567.
  - `rotateBy`=36 behaves as 4 and gives the same result.
  - `rotateBy`=32 gives 32'h1234_5678 with `done` in the cycle after accept and `busy` never high.
- Full sweep and latency: 32'hA5A5_0F0F by 31 gives 32'h4B4A_1E1F.
  - Default build: 31 `busy` cycles.
  - `ROR_NIBBLE_STEP_EN` build: 10 `busy` cycles.
  - Check against a reference model for all n in 0..31.
- Ignored start and back-to-back:
  - Pulse `start` with new data mid-SHIFT: the first result is unaffected.
  - `start` during DONE is accepted, with no IDLE cycle in between.
- Clear mid-operation: `clear` at the 3rd SHIFT cycle of a rotate by 10 gives state IDLE, `rotated`=0, and no `done` pulse afterwards.

Source files
------------

// File: rtl/rotate_right_seq.sv
// Multi-cycle rotate-right unit: rotates a latched operand one bit per clock, then pulses done.
// Build option ROR_NIBBLE_STEP_EN: step by 4 bits while at least 4 positions remain.
module rotate_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] unrotated,
  input  logic [WIDTH-1:0] rotateBy,
  output logic [WIDTH-1:0] rotated,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state;
  logic [SHAMT_W-1:0]   remaining;
  logic [WIDTH-1:0]     step_data;
  logic [SHAMT_W-1:0]   step_rem;
  logic                 unused_upper;

  // Amount bits above the shift range are deliberately discarded (32 acts as 0).
  assign unused_upper = ^rotateBy[WIDTH-1:SHAMT_W];

  always_comb begin
    step_data = {rotated[0], rotated[WIDTH-1:1]};
    step_rem  = remaining - SHAMT_W'(1);
`ifdef ROR_NIBBLE_STEP_EN
    if (remaining >= SHAMT_W'(4)) begin
      step_data = {rotated[3:0], rotated[WIDTH-1:4]};
      step_rem  = remaining - SHAMT_W'(4);
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      rotated   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rotated   <= unrotated;
            remaining <= rotateBy[SHAMT_W-1:0];
            if (rotateBy[SHAMT_W-1:0] != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is ignored here; the operation in flight runs to completion.
          rotated   <= step_data;
          remaining <= step_rem;
          if (step_rem == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SHIFT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_right_seq.sv
// Scoreboard bench for rotate_right_seq: expected results queued at issue, checked on done.
module tb_rotate_right_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] unrotated;
  logic [31:0] rotateBy;
  logic [31:0] rotated;
  logic        busy;
  logic        done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_result = '0;

  rotate_right_seq dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .unrotated(unrotated),
    .rotateBy (rotateBy),
    .rotated  (rotated),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic int exp_lat(input int n);
`ifdef ROR_NIBBLE_STEP_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Called just after a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [31:0] d, input logic [31:0] amt);
    int n;
    n = int'(amt[4:0]);
    start = 1'b1;
    unrotated = d;
    rotateBy = amt;
    exp_q.push_back(ror(d, n));
    lat_q.push_back(exp_lat(n));
    @(negedge clock);
    start = 1'b0;
    unrotated = $urandom;
    rotateBy = $urandom;
  endtask

  // Waits for done (bounded), then checks result, latency and busy cycle count.
  task automatic collect(input string name, input int pulse_at);
    int cycles = 0;
    int busy_cnt = 0;
    logic [31:0] e;
    int l;
    while (done !== 1'b1 && cycles < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (cycles == pulse_at) begin
        start = 1'b1;
        unrotated = $urandom;
        rotateBy = 32'd5;
      end else if (cycles == pulse_at + 1) begin
        start = 1'b0;
      end
      @(negedge clock);
      cycles++;
    end
    if (pulse_at >= 0) start = 1'b0;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    vectors++;
    if (cycles >= 200) begin
      miscompares++;
      $display("FAIL %s timeout: done not seen after %0d cycles, required within %0d", name, cycles, l);
      return;
    end
    vectors++;
    if (rotated !== e) begin
      miscompares++;
      $display("FAIL %s result: rotated=%h expected=%h", name, rotated, e);
    end
    vectors++;
    if (cycles != l) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles expected %0d", name, cycles, l);
    end
    vectors++;
    if (busy_cnt != l) begin
      miscompares++;
      $display("FAIL %s busy: high %0d cycles expected %0d", name, busy_cnt, l);
    end
    last_result = e;
    $display("%s: rotated=%h expect=%h latency=%0d busy=%0d", name, rotated, e, cycles, busy_cnt);
  endtask

  // One cycle after done with no new request: idle, pulse gone, result held.
  task automatic check_idle(input string name);
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || rotated !== last_result) begin
      miscompares++;
      $display("FAIL %s idle: done=%b busy=%b rotated=%h expected done=0 busy=0 rotated=%h",
               name, done, busy, rotated, last_result);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b0;
    unrotated = 32'hDEAD_BEEF;
    rotateBy = 32'd7;
    repeat (2) @(negedge clock);
    vectors++;
    if (rotated !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rotated=%h busy=%b done=%b expected 0/0/0", rotated, busy, done);
    end
    clear = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (rotated !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: rotated=%h busy=%b done=%b expected 0/0/0", rotated, busy, done);
    end
    $display("reset: rotated=%h busy=%b done=%b", rotated, busy, done);
  endtask

  task automatic test_basic();
    issue(32'h0000_0001, 32'd1);
    collect("basic_1", -1);
    vectors++;
    if (rotated !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL basic_const: rotated=%h expected 80000000", rotated);
    end
    check_idle("basic_1");
  endtask

  task automatic test_masking();
    issue(32'h1234_5678, 32'd4);
    collect("rot_4", -1);
    vectors++;
    if (rotated !== 32'h8123_4567) begin
      miscompares++;
      $display("FAIL rot_4_const: rotated=%h expected 81234567", rotated);
    end
    issue(32'h1234_5678, 32'd36);
    collect("rot_36", -1);
    vectors++;
    if (rotated !== 32'h8123_4567) begin
      miscompares++;
      $display("FAIL rot_36_const: rotated=%h expected 81234567", rotated);
    end
    issue(32'h1234_5678, 32'd32);
    collect("rot_32", -1);
    vectors++;
    if (rotated !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL rot_32_const: rotated=%h expected 12345678", rotated);
    end
    issue(32'hCAFE_0001, 32'hFFFF_FFE1);
    collect("rot_upper_masked", -1);
    check_idle("masking");
  endtask

  task automatic test_sweep();
    issue(32'hA5A5_0F0F, 32'd31);
    collect("rot_31", -1);
    vectors++;
    if (rotated !== 32'h4B4A_1E1F) begin
      miscompares++;
      $display("FAIL rot_31_const: rotated=%h expected 4b4a1e1f", rotated);
    end
    check_idle("rot_31");
    for (int n = 0; n < 32; n++) begin
      issue($urandom, 32'(n) | ({$urandom} << 5));
      collect($sformatf("sweep_%0d", n), -1);
      check_idle($sformatf("sweep_%0d", n));
    end
  endtask

  task automatic test_ignored_start();
    issue(32'h0F0F_1234, 32'd10);
    collect("ignored_start", 3);
    check_idle("ignored_start");
    repeat (3) check_idle("ignored_start_noqueue");
  endtask

  task automatic test_back_to_back();
    issue(32'h8765_4321, 32'd3);
    collect("b2b_first", -1);
    issue(32'h0000_FFFF, 32'd2);
    collect("b2b_second", -1);
    issue(32'h1111_2222, 32'd0);
    collect("stream0_a", -1);
    issue(32'h3333_4444, 32'd32);
    collect("stream0_b", -1);
    issue(32'h5555_6666, 32'd0);
    collect("stream0_c", -1);
    check_idle("back_to_back");
  endtask

  task automatic test_clear_mid();
    issue(32'hFEDC_BA98, 32'd10);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_pre_busy: busy=%b expected 1", busy);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    vectors++;
    if (rotated !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid: rotated=%h busy=%b done=%b expected 0/0/0", rotated, busy, done);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_no_done: cycle %0d done=%b busy=%b expected 0/0", i, done, busy);
      end
    end
    $display("clear_mid: rotated=%h busy=%b done=%b", rotated, busy, done);
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    unrotated = '0;
    rotateBy = '0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_masking();
    test_sweep();
    test_ignored_start();
    test_back_to_back();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
